// File: rtl/bits_imem_controller.sv
// bits_imem_controller: instruction-memory fetch controller for the BITS decoder core.
// Each active-low request from the core causes one 128-bit word to be read from the
// single-port instruction SRAM. The word is returned with a per-byte valid mask that
// reflects how many of the programmed bytes are still outstanding. Once every byte
// has been delivered, done_reading_memory is raised and stays set.

module bits_imem_controller #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              resetB,
    input  logic              start,
    input  logic [15:0]       expectedBytes,
    input  logic              mem_req_b,
    output logic              mem_ack_b,
    output logic [127:0]      instruction_word,
    output logic [15:0]       instruction_byte_valid,
    output logic              done_reading_memory,
    output logic              busy,
    output logic              imem_ceb,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [127:0]      imem_rdata
);

    // Bytes carried by one SRAM word.
    localparam logic [15:0] WORD_BYTES = 16'd16;

    // DONE_REQ is the single filler cycle used when a request arrives after
    // every byte has been delivered; it has no SRAM access, so the ack
    // arrives one cycle sooner than on a real read.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        READ     = 3'd2,
        CAPTURE  = 3'd3,
        ACK      = 3'd4,
        RELEASE  = 3'd5,
        DONE     = 3'd6,
        DONE_REQ = 3'd7
    } state_t;

    state_t state_q;
    state_t state_d;

    // Bytes still to be delivered and the word address of the next read.
    logic [15:0]       rem_q;
    logic [15:0]       rem_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Next values of the registered outputs.
    logic              mem_ack_b_d;
    logic [127:0]      instruction_word_d;
    logic [15:0]       instruction_byte_valid_d;
    logic              done_reading_memory_d;
    logic              busy_d;
    logic              imem_ceb_d;
    logic [ADDR_W-1:0] imem_addr_d;

    // Capture-time helpers: mask for the word being captured and bytes left afterwards.
    logic [15:0] capture_mask;
    logic [15:0] rem_after;

    // A start pulse only counts when no transfer is in progress.
    logic start_accept;
    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));

    // State register.
    always_ff @(posedge clk) begin
        if (resetB) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the fetch handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (expectedBytes == 16'd0) ? DONE : ARMED;
                end
            end
            ARMED: begin
                if (!mem_req_b) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = ACK;
            end
            ACK: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (mem_req_b) begin
                    state_d = (rem_q != 16'd0) ? ARMED : DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = (expectedBytes == 16'd0) ? DONE : ARMED;
                end else if (!mem_req_b) begin
                    state_d = DONE_REQ;
                end
            end
            DONE_REQ: begin
                state_d = ACK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath next values, derived from the current and next state.
    always_comb begin
        capture_mask = (rem_q >= WORD_BYTES) ? 16'hFFFF : ~(16'hFFFF >> rem_q[3:0]);
        rem_after    = (rem_q >= WORD_BYTES) ? (rem_q - WORD_BYTES) : 16'd0;

        rem_d                    = rem_q;
        addr_d                   = addr_q;
        instruction_word_d       = instruction_word;
        instruction_byte_valid_d = instruction_byte_valid;
        done_reading_memory_d    = done_reading_memory;
        imem_addr_d              = imem_addr;

        if (start_accept) begin
            rem_d                 = expectedBytes;
            addr_d                = BASE_ADDR;
            done_reading_memory_d = (expectedBytes == 16'd0);
        end

        if (state_q == CAPTURE) begin
            instruction_word_d       = imem_rdata;
            instruction_byte_valid_d = capture_mask;
            rem_d                    = rem_after;
            addr_d                   = addr_q + ADDR_W'(1);
        end

        if (state_q == DONE_REQ) begin
            instruction_byte_valid_d = 16'h0000;
        end

        if (state_d == READ) begin
            imem_addr_d = addr_q;
        end

        if ((state_d == ACK) && (rem_d == 16'd0)) begin
            done_reading_memory_d = 1'b1;
        end

        imem_ceb_d  = (state_d != READ);
        mem_ack_b_d = (state_d != ACK);
        busy_d      = !((state_d == IDLE) || (state_d == DONE));
    end

    // Output and datapath registers; reset discards any read in flight.
    always_ff @(posedge clk) begin
        if (resetB) begin
            rem_q                  <= 16'd0;
            addr_q                 <= BASE_ADDR;
            mem_ack_b              <= 1'b1;
            instruction_word       <= 128'd0;
            instruction_byte_valid <= 16'h0000;
            done_reading_memory    <= 1'b0;
            busy                   <= 1'b0;
            imem_ceb               <= 1'b1;
            imem_addr              <= BASE_ADDR;
        end else begin
            rem_q                  <= rem_d;
            addr_q                 <= addr_d;
            mem_ack_b              <= mem_ack_b_d;
            instruction_word       <= instruction_word_d;
            instruction_byte_valid <= instruction_byte_valid_d;
            done_reading_memory    <= done_reading_memory_d;
            busy                   <= busy_d;
            imem_ceb               <= imem_ceb_d;
            imem_addr              <= imem_addr_d;
        end
    end

endmodule

// File: tb/tb_bits_imem_controller.sv
// tb_bits_imem_controller: directed bench for the instruction-memory fetch controller.
// A behavioural SRAM returns an address-tagged word one cycle after a read, and the
// core side is driven as a well-behaved requester except where a case needs otherwise.

module tb_bits_imem_controller;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              resetB;
    logic              start;
    logic [15:0]       expectedBytes;
    logic              mem_req_b;
    logic              mem_ack_b;
    logic [127:0]      instruction_word;
    logic [15:0]       instruction_byte_valid;
    logic              done_reading_memory;
    logic              busy;
    logic              imem_ceb;
    logic [ADDR_W-1:0] imem_addr;
    logic [127:0]      imem_rdata;

    int total;
    int bad;
    int ceb_pulses;
    int ack_pulses;

    typedef struct {
        logic [15:0] bytes;
        int          reads;
        logic [15:0] last_valid;
    } vec_t;

    vec_t vecs [8];

    bits_imem_controller #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (12'd0)
    ) dut (
        .clk                    (clk),
        .resetB                 (resetB),
        .start                  (start),
        .expectedBytes          (expectedBytes),
        .mem_req_b              (mem_req_b),
        .mem_ack_b              (mem_ack_b),
        .instruction_word       (instruction_word),
        .instruction_byte_valid (instruction_byte_valid),
        .done_reading_memory    (done_reading_memory),
        .busy                   (busy),
        .imem_ceb               (imem_ceb),
        .imem_addr              (imem_addr),
        .imem_rdata             (imem_rdata)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of SRAM word a, tagged with its address so misaddressed reads show up.
    function automatic logic [127:0] word_of(input logic [ADDR_W-1:0] a);
        return {4{20'hC0DE0, a}};
    endfunction

    // SRAM model: data one cycle after a read, junk otherwise so a mistimed capture is visible.
    always @(posedge clk) begin
        if (!imem_ceb) begin
            imem_rdata <= word_of(imem_addr);
        end else begin
            imem_rdata <= {8{16'hBAD0}};
        end
    end

    // Count SRAM read cycles and ack cycles while out of reset.
    always @(negedge clk) begin
        if (!resetB) begin
            if (!imem_ceb) ceb_pulses <= ceb_pulses + 1;
            if (!mem_ack_b) ack_pulses <= ack_pulses + 1;
        end
    end

    // Hard stop in case something hangs outside the bounded loops.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Pulse start for one cycle with the given byte count.
    task automatic apply_stimulus(input logic [15:0] bytes);
        start         = 1'b1;
        expectedBytes = bytes;
        step();
        start         = 1'b0;
        expectedBytes = 16'hFFFF;
    endtask

    // One request/ack handshake followed by a release of the request.
    task automatic do_request(input string tag, input int exp_lat, input int exp_reads,
                              input logic [ADDR_W-1:0] exp_addr, input logic [15:0] exp_valid,
                              input logic [127:0] exp_word, input logic exp_done);
        int   k;
        int   ceb0;
        logic got;
        ceb0      = ceb_pulses;
        got       = 1'b0;
        k         = 0;
        mem_req_b = 1'b0;
        while (!got && k < 20) begin
            step();
            k = k + 1;
            if (!imem_ceb) check_output({tag, " addr"}, 128'(imem_addr), 128'(exp_addr));
            if (!mem_ack_b) got = 1'b1;
        end
        check_output({tag, " ack seen"}, 128'(got), 128'(1));
        if (got) begin
            check_output({tag, " latency"}, 128'(k), 128'(exp_lat));
            check_output({tag, " valid"}, 128'(instruction_byte_valid), 128'(exp_valid));
            check_output({tag, " word"}, instruction_word, exp_word);
            check_output({tag, " done"}, 128'(done_reading_memory), 128'(exp_done));
        end
        mem_req_b = 1'b1;
        step();
        check_output({tag, " ack width"}, 128'(mem_ack_b), 128'(1));
        check_output({tag, " reads"}, 128'(ceb_pulses - ceb0), 128'(exp_reads));
    endtask

    initial begin
        int          ceb0;
        int          ack0;
        int          first_ack;
        logic [15:0] exp_valid;

        total         = 0;
        bad           = 0;
        ceb_pulses    = 0;
        ack_pulses    = 0;
        resetB        = 1'b1;
        start         = 1'b0;
        expectedBytes = 16'd0;
        mem_req_b     = 1'b1;

        vecs[0] = '{bytes: 16'd40, reads: 3, last_valid: 16'hFF00};
        vecs[1] = '{bytes: 16'd33, reads: 3, last_valid: 16'h8000};
        vecs[2] = '{bytes: 16'd16, reads: 1, last_valid: 16'hFFFF};
        vecs[3] = '{bytes: 16'd17, reads: 2, last_valid: 16'h8000};
        vecs[4] = '{bytes: 16'd32, reads: 2, last_valid: 16'hFFFF};
        vecs[5] = '{bytes: 16'd1,  reads: 1, last_valid: 16'h8000};
        vecs[6] = '{bytes: 16'd20, reads: 2, last_valid: 16'hF000};
        vecs[7] = '{bytes: 16'd5,  reads: 1, last_valid: 16'hF800};

        // Reset values.
        step();
        step();
        check_output("reset ack", 128'(mem_ack_b), 128'(1));
        check_output("reset ceb", 128'(imem_ceb), 128'(1));
        check_output("reset addr", 128'(imem_addr), 128'(0));
        check_output("reset word", instruction_word, 128'd0);
        check_output("reset valid", 128'(instruction_byte_valid), 128'(0));
        check_output("reset done", 128'(done_reading_memory), 128'(0));
        check_output("reset busy", 128'(busy), 128'(0));
        resetB = 1'b0;
        step();

        // Zero-byte transfer: done the next cycle, no SRAM access.
        ceb0 = ceb_pulses;
        apply_stimulus(16'd0);
        check_output("zero done", 128'(done_reading_memory), 128'(1));
        check_output("zero busy", 128'(busy), 128'(0));
        repeat (4) step();
        check_output("zero reads", 128'(ceb_pulses - ceb0), 128'(0));

        // Table of single transfers; the last two run back to back.
        for (int v = 0; v < 8; v++) begin
            apply_stimulus(vecs[v].bytes);
            check_output($sformatf("v%0d start done", v), 128'(done_reading_memory), 128'(0));
            check_output($sformatf("v%0d start busy", v), 128'(busy), 128'(1));
            for (int r = 0; r < vecs[v].reads; r++) begin
                exp_valid = (r == vecs[v].reads - 1) ? vecs[v].last_valid : 16'hFFFF;
                do_request($sformatf("v%0d r%0d", v, r), 3, 1, ADDR_W'(r), exp_valid,
                           word_of(ADDR_W'(r)), (r == vecs[v].reads - 1));
                step();
                step();
            end
            check_output($sformatf("v%0d end done", v), 128'(done_reading_memory), 128'(1));
            check_output($sformatf("v%0d end busy", v), 128'(busy), 128'(0));
        end

        // Request after completion: ack two cycles later, empty mask, word unchanged.
        do_request("done req", 2, 0, '0, 16'h0000, word_of(12'd0), 1'b1);
        step();
        step();
        check_output("done req busy", 128'(busy), 128'(0));

        // Request held low: exactly one read and one ack.
        apply_stimulus(16'd16);
        ceb0      = ceb_pulses;
        ack0      = ack_pulses;
        first_ack = 0;
        mem_req_b = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (!mem_ack_b && first_ack == 0) first_ack = k;
        end
        check_output("held latency", 128'(first_ack), 128'(3));
        check_output("held reads", 128'(ceb_pulses - ceb0), 128'(1));
        check_output("held acks", 128'(ack_pulses - ack0), 128'(1));
        mem_req_b = 1'b1;
        repeat (3) step();
        check_output("held done", 128'(done_reading_memory), 128'(1));
        check_output("held busy", 128'(busy), 128'(0));

        // Start while a transfer is armed is ignored.
        apply_stimulus(16'd33);
        do_request("ign r0", 3, 1, 12'd0, 16'hFFFF, word_of(12'd0), 1'b0);
        step();
        step();
        apply_stimulus(16'd100);
        check_output("ign busy", 128'(busy), 128'(1));
        check_output("ign done", 128'(done_reading_memory), 128'(0));
        do_request("ign r1", 3, 1, 12'd1, 16'hFFFF, word_of(12'd1), 1'b0);
        step();
        step();
        do_request("ign r2", 3, 1, 12'd2, 16'h8000, word_of(12'd2), 1'b1);
        repeat (3) step();
        check_output("ign end busy", 128'(busy), 128'(0));

        // Reset while the controller is in CAPTURE.
        apply_stimulus(16'd40);
        mem_req_b = 1'b0;
        step();
        step();
        resetB = 1'b1;
        step();
        check_output("rst ack", 128'(mem_ack_b), 128'(1));
        check_output("rst ceb", 128'(imem_ceb), 128'(1));
        check_output("rst busy", 128'(busy), 128'(0));
        check_output("rst valid", 128'(instruction_byte_valid), 128'(0));
        check_output("rst word", instruction_word, 128'd0);
        resetB = 1'b0;
        ceb0   = ceb_pulses;
        ack0   = ack_pulses;
        repeat (6) step();
        check_output("rst no ack", 128'(ack_pulses - ack0), 128'(0));
        check_output("rst no read", 128'(ceb_pulses - ceb0), 128'(0));
        mem_req_b = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bits_imem_controller.md
Name: bits_imem_controller

Overview:
- Instruction-memory fetch controller that feeds the BITS decoder core.
- Services the core's active-low fetch request (mem_req_b / mem_ack_b).
- Reads 128-bit words from a single-port instruction SRAM, starting at BASE_ADDR.
- Returns each word with a per-byte valid mask, derived from the byte count programmed by the register block.
- Signals done_reading_memory once the programmed byte count has been delivered.

Parameters:
- ADDR_W, 12, instruction SRAM word-address width; 4096 words covers the 65535-byte maximum.
- BASE_ADDR, 0, word address of the first instruction word.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- resetB  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse from bits_regs; begins a transfer.
- expectedBytes  input  16  total valid instruction bytes; sampled on an accepted start.
- mem_req_b  input  1  active-low, level fetch request from the core.
- mem_ack_b  output  1  active-low, one-cycle fetch acknowledge.
- instruction_word  output  128  fetched word; byte 0 is bits [127:120].
- instruction_byte_valid  output  16  bit 15 corresponds to byte 0 (MSB-first).
- done_reading_memory  output  1  all expected bytes delivered; sticky.
- busy  output  1  high in every state except IDLE and DONE.
- imem_ceb  output  1  active-low SRAM read enable.
- imem_addr  output  ADDR_W  SRAM word address.
- imem_rdata  input  128  SRAM read data, valid one cycle after imem_ceb is low.

Behaviour:
- All outputs are registered.
- Reset values:
  - mem_ack_b=1, imem_ceb=1.
  - imem_addr=BASE_ADDR.
  - instruction_word=0, instruction_byte_valid=0.
  - done_reading_memory=0, busy=0.
  - State IDLE.
- Internal registers:
  - rem[15:0]: bytes remaining.
  - addr[ADDR_W-1:0]: current word address.
- IDLE:
  - start=1 latches rem=expectedBytes, addr=BASE_ADDR, clears done_reading_memory.
  - rem!=0: go to ARMED.
  - expectedBytes=0: go straight to DONE; done_reading_memory=1 on the next cycle; no SRAM access.
- ARMED:
  - mem_req_b=0 sampled: go to READ.
  - Otherwise remain in ARMED.
- READ (one cycle): imem_ceb=0, imem_addr=addr; go to CAPTURE.
- CAPTURE (one cycle):
  - imem_ceb=1.
  - instruction_word <= imem_rdata.
  - instruction_byte_valid <= (rem>=16) ? 16'hFFFF : upper rem bits set, i.e. ~(16'hFFFF >> rem).
  - rem <= rem - min(rem,16); addr <= addr+1.
  - Go to ACK.
- ACK (one cycle):
  - mem_ack_b=0.
  - If rem==0, done_reading_memory=1 in this same cycle; it stays set until the next accepted start or reset.
  - Go to RELEASE.
- RELEASE:
  - Wait for mem_req_b=1 so a held request is never double-serviced.
  - Then go to ARMED if rem!=0, else DONE.
- DONE:
  - A request (mem_req_b=0 after a release) gets an ACK pulse 2 cycles later, with instruction_byte_valid=0 and instruction_word unchanged.
  - No SRAM access; return via RELEASE to DONE.
  - start=1 behaves as in IDLE.
- Latency: request sampled low at edge N → imem_ceb low in cycle N+1 → data captured at end of N+2 → mem_ack_b low in cycle N+3.
- instruction_word and instruction_byte_valid hold from capture until the next capture.
- start outside IDLE/DONE is ignored: no change to rem, addr or done.
- addr wraps modulo 2^ADDR_W. No error flag is raised.
- Reset asserted in any state returns to reset values on the next edge. Any in-flight read is discarded and no ack is issued.

Test Plan:
- expectedBytes=40; core requests, releases after each ack → 3 reads at addr 0,1,2; valid=FFFF, FFFF, FF00; done_reading_memory=1 with the 3rd mem_ack_b=0; rem=0.
- expectedBytes=0, start → done=1 one cycle later; imem_ceb never low; a subsequent request → ack with valid=0000.
- expectedBytes=16, mem_req_b held low 10 cycles → exactly one imem_ceb pulse and one ack; ack at 3 cycles after the request is sampled.
- start pulsed while in ARMED with expectedBytes=100 (active transfer 33 bytes) → ignored; total 3 reads; last valid=8000.
- resetB asserted during CAPTURE → next cycle: mem_ack_b=1, imem_ceb=1, busy=0, valid=0; no ack follows.
- Back-to-back transfers: 20 bytes, done, then start with 5 bytes → done clears on start; a single read at BASE_ADDR with valid=F800.
